// File: rtl/neuron_pkg.sv
// Shared types for the neuron operand path: operand width, operand type and feeder FSM states.
package neuron_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        FD_IDLE,
        FD_STREAM,
        FD_DONE
    } feeder_state_t;

endpackage

// File: rtl/feeder_regfile.sv
// Paired x/w register file: one shared write port, one asynchronous read port, cleared on reset.
module feeder_regfile
    import neuron_pkg::*;
#(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned AW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wx,
    input  logic [DATA_W-1:0] ww,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rx,
    output logic [DATA_W-1:0] rw
);

    logic [DATA_W-1:0] regx [N_INPUTS];
    logic [DATA_W-1:0] regw [N_INPUTS];

    // Storage: clear every entry on reset, write both arrays at one address on we.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_INPUTS); i++) begin
                regx[i] <= '0;
                regw[i] <= '0;
            end
        end else if (we) begin
            regx[waddr] <= wx;
            regw[waddr] <= ww;
        end
    end

    assign rx = regx[raddr];
    assign rw = regw[raddr];

endmodule

// File: rtl/neuron_feeder.sv
// Operand sequencer: streams stored (x, w) pairs one per accepted beat, framed with last and done.
module neuron_feeder
    import neuron_pkg::*;
#(
    parameter  int unsigned N_INPUTS = 4,
    localparam int unsigned AW       = $clog2(N_INPUTS),
    localparam int unsigned LW       = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_x,
    input  logic [DATA_W-1:0] load_w,
    input  logic [LW-1:0]     len,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] w_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done
);

    feeder_state_t     state_q, state_nxt;
    logic [LW-1:0]     idx_q, idx_nxt;
    logic [LW-1:0]     len_q, len_nxt;
    logic              busy_q, busy_nxt;
    logic              valid_q, valid_nxt;
    logic              last_q, last_nxt;
    logic              done_q, done_nxt;
    logic [DATA_W-1:0] x_q, x_nxt;
    logic [DATA_W-1:0] w_q, w_nxt;

    logic              wr_en_c;
    logic [AW-1:0]     rd_addr_c;
    logic [DATA_W-1:0] rf_x_c;
    logic [DATA_W-1:0] rf_w_c;
    logic [DATA_W-1:0] x_rd_c;
    logic [DATA_W-1:0] w_rd_c;
    logic [LW-1:0]     len_clamp_c;
    logic              load_out_c;

    // Writes land only while idle so the vectors stay frozen for the whole run.
    assign wr_en_c = load_en && (state_q == FD_IDLE)
                     && ({1'b0, load_addr} < LW'(N_INPUTS));

    // Read the element that will be presented next: entry 0 on a start, idx+1 while streaming.
    assign rd_addr_c = (state_q == FD_STREAM) ? (idx_q[AW-1:0] + AW'(1)) : '0;

    // A write in the same cycle as a start is forwarded so the run sees the new value.
    assign x_rd_c = (wr_en_c && (load_addr == rd_addr_c)) ? load_x : rf_x_c;
    assign w_rd_c = (wr_en_c && (load_addr == rd_addr_c)) ? load_w : rf_w_c;

    assign len_clamp_c = (len > LW'(N_INPUTS)) ? LW'(N_INPUTS) : len;

    feeder_regfile #(
        .N_INPUTS (N_INPUTS),
        .AW       (AW)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en_c),
        .waddr (load_addr),
        .wx    (load_x),
        .ww    (load_w),
        .raddr (rd_addr_c),
        .rx    (rf_x_c),
        .rw    (rf_w_c)
    );

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_nxt  = state_q;
        idx_nxt    = idx_q;
        len_nxt    = len_q;
        busy_nxt   = busy_q;
        valid_nxt  = valid_q;
        last_nxt   = last_q;
        done_nxt   = 1'b0;
        x_nxt      = x_q;
        w_nxt      = w_q;
        load_out_c = 1'b0;

        case (state_q)
            FD_IDLE: begin
                if (start) begin
                    len_nxt  = len_clamp_c;
                    idx_nxt  = '0;
                    busy_nxt = 1'b1;
                    if (len_clamp_c == '0) begin
                        state_nxt = FD_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt  = FD_STREAM;
                        valid_nxt  = 1'b1;
                        load_out_c = 1'b1;
                    end
                end
            end
            FD_STREAM: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        state_nxt = FD_DONE;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt    = idx_q + LW'(1);
                        load_out_c = 1'b1;
                    end
                end
            end
            FD_DONE: begin
                state_nxt = FD_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = FD_IDLE;
                busy_nxt  = 1'b0;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase

        if (load_out_c) begin
            x_nxt    = x_rd_c;
            w_nxt    = w_rd_c;
            last_nxt = (idx_nxt == (len_nxt - LW'(1)));
        end
    end

    // State, index and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FD_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            len_q   <= len_nxt;
            busy_q  <= busy_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
            done_q  <= done_nxt;
            x_q     <= x_nxt;
            w_q     <= w_nxt;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign x_out     = x_q;
    assign w_out     = w_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Scoreboard bench for neuron_feeder: directed runs push expected beats, a monitor pops on each accept.
module tb_neuron_feeder;

    logic       clk;
    logic       rst;
    logic       load_en;
    logic [1:0] load_addr;
    logic [7:0] load_x;
    logic [7:0] load_w;
    logic [2:0] len;
    logic       start;
    logic       busy;
    logic [7:0] x_out;
    logic [7:0] w_out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       done;

    typedef struct {
        int x;
        int w;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    exp_done;
    int    checks;
    int    failures;
    int    vx[4];
    int    vw[4];

    neuron_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_x    (load_x),
        .load_w    (load_w),
        .len       (len),
        .start     (start),
        .busy      (busy),
        .x_out     (x_out),
        .w_out     (w_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int addr, int x, int w);
        load_en   = 1'b1;
        load_addr = 2'(addr);
        load_x    = 8'(x);
        load_w    = 8'(w);
        vx[addr]  = x;
        vw[addr]  = w;
        tick();
        load_en   = 1'b0;
    endtask

    // Push the first n_push beats of a run of length run_len, then pulse start.
    task automatic start_run(int l, int n_push, int run_len, int with_done);
        for (int i = 0; i < n_push; i++) begin
            beat_t b;
            b.x    = vx[i];
            b.w    = vw[i];
            b.last = (i == run_len - 1) ? 1 : 0;
            exp_q.push_back(b);
        end
        if (with_done != 0) exp_done++;
        len   = 3'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called just after a rising edge; that cycle counts as 1. Bounded wait for done.
    task automatic wait_done(string name, int exp_n);
        int n;
        n = 1;
        @(negedge clk);
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
        end
        check(name, n, exp_n);
    endtask

    // Monitor: compare every accepted beat and every done pulse against the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_x", int'($signed(x_out)), e.x);
                    check("beat_w", int'($signed(w_out)), e.w);
                    check("beat_last", int'(out_last), e.last);
                end
            end
            if (done) begin
                check("done_expected", (exp_done > 0) ? 1 : 0, 1);
                check("done_beats_drained", exp_q.size(), 0);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_x    = '0;
        load_w    = '0;
        len       = '0;
        start     = 1'b0;
        out_ready = 1'b0;
        exp_done  = 0;
        checks    = 0;
        failures  = 0;
        for (int i = 0; i < 4; i++) begin
            vx[i] = 0;
            vw[i] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_w", int'(w_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // 1: full-throughput run
        load(0, 1, 5);
        load(1, -2, 6);
        load(2, 3, -7);
        load(3, 4, 8);
        out_ready = 1'b1;
        start_run(4, 4, 4, 1);
        wait_done("t1_done_lat", 5);
        check("t1_busy_at_done", int'(busy), 1);
        tick();
        @(negedge clk);
        check("t1_busy_after", int'(busy), 0);
        tick();

        // 2: three-cycle stall on beat 2
        start_run(4, 4, 4, 1);
        tick();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t2_hold_valid", int'(out_valid), 1);
            check("t2_hold_x", int'($signed(x_out)), -2);
            check("t2_hold_w", int'($signed(w_out)), 6);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_done("t2_done_lat", 4);
        tick();

        // 3: zero-length run, then clamped length
        start_run(0, 0, 0, 1);
        @(negedge clk);
        check("t3_len0_valid", int'(out_valid), 0);
        check("t3_len0_busy", int'(busy), 1);
        check("t3_len0_done", int'(done), 1);
        tick();
        @(negedge clk);
        check("t3_len0_busy_after", int'(busy), 0);
        check("t3_len0_done_after", int'(done), 0);
        tick();
        start_run(7, 4, 4, 1);
        wait_done("t3_clamp_done", 5);
        tick();

        // 4: start and load during a run are ignored
        start_run(4, 4, 4, 1);
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 2'd0;
        load_x    = 8'd99;
        load_w    = 8'd99;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        wait_done("t4_done_lat", 4);
        tick();
        tick();
        @(negedge clk);
        check("t4_no_queued_run", int'(busy), 0);
        tick();
        // Simultaneous load and start: the run reads the new entry
        load_en   = 1'b1;
        load_addr = 2'd1;
        load_x    = 8'(50);
        load_w    = 8'(-50);
        vx[1]     = 50;
        vw[1]     = -50;
        start_run(2, 2, 2, 1);
        load_en = 1'b0;
        wait_done("t4_b_done", 3);

        // 6: back-to-back run started in the cycle after done
        @(posedge clk);
        #1;
        start_run(3, 3, 3, 1);
        @(negedge clk);
        check("t6_first_valid", int'(out_valid), 1);
        check("t6_first_x", int'($signed(x_out)), 1);
        @(posedge clk);
        #1;
        wait_done("t6_done_lat", 3);
        tick();

        // 5: reset mid-run after beat 2
        start_run(4, 2, 4, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t5_busy", int'(busy), 0);
        check("t5_valid", int'(out_valid), 0);
        check("t5_last", int'(out_last), 0);
        check("t5_done", int'(done), 0);
        check("t5_x", int'(x_out), 0);
        check("t5_w", int'(w_out), 0);
        for (int i = 0; i < 4; i++) begin
            vx[i] = 0;
            vw[i] = 0;
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        start_run(4, 4, 4, 1);
        wait_done("t5_done_lat", 5);
        tick();
        tick();

        check("end_beats_left", exp_q.size(), 0);
        check("end_dones_left", exp_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
